pipe_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage pipeline (F/D/E/M/W).

---
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-side status in, stall/flush/forward controls out.
// master = pipeline side that reports hazards, slave = the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW, MemtoRegE, MemWriteM, MemtoRegM;
  logic             PCWrPendingF, BranchTakenE, PCSrcW, mem_ready, cnt_clr;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic             mem_req, mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, MemWriteM, MemtoRegM,
           PCWrPendingF, BranchTakenE, PCSrcW, mem_ready, cnt_clr,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_req, mem_timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, MemWriteM, MemtoRegM,
           PCWrPendingF, BranchTakenE, PCSrcW, mem_ready, cnt_clr,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_req, mem_timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use/branch stall+flush,
// data-memory wait-state FSM with sticky timeout trap, saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int RA_W        = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t           state_q;
  logic [WC_W-1:0]  wait_cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [RA_W-1:0]  ra1d, ra2d, wa3e;
  logic             ldr_stall, mem_acc, mem_stall;
  logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;

  assign ra1d = hz.RA1D;
  assign ra2d = hz.RA2D;
  assign wa3e = hz.WA3E;

  assign ldr_stall = hz.MemtoRegE & ((ra1d == wa3e) | (ra2d == wa3e));
  assign mem_acc   = hz.MemWriteM | hz.MemtoRegM;
  assign mem_stall = ((state_q == IDLE) & mem_acc & ~hz.mem_ready) |
                     ((state_q == WAIT) & ~hz.mem_ready) |
                     (state_q == ERR);

  // M has the youngest result, so it wins over W.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hz.RA1E == hz.WA3M)      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hz.RA1E == hz.WA3W) hz.ForwardAE = 2'b01;
    if (hz.RegWriteM && hz.RA2E == hz.WA3M)      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hz.RA2E == hz.WA3W) hz.ForwardBE = 2'b01;
  end

  // A memory stall freezes F..M and defers any flush; E re-evaluates after release.
  always_comb begin
    stall_f = ldr_stall | hz.PCWrPendingF;
    stall_d = ldr_stall;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
    flush_e = ldr_stall | hz.BranchTakenE;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b1;
    end
  end

  assign hz.StallF          = stall_f;
  assign hz.StallD          = stall_d;
  assign hz.StallE          = stall_e;
  assign hz.StallM          = stall_m;
  assign hz.FlushD          = flush_d;
  assign hz.FlushE          = flush_e;
  assign hz.FlushW          = flush_w;
  assign hz.mem_req         = mem_acc & (state_q != ERR);
  assign hz.mem_timeout_err = err_q;
  assign hz.stall_cnt       = stall_cnt_q;
  assign hz.flush_cnt       = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (mem_acc && !hz.mem_ready) begin
          state_q    <= WAIT;
          wait_cnt_q <= WC_W'(1);
        end
        WAIT: if (hz.mem_ready) begin
          state_q <= IDLE;
        end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        ERR:     state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_f && !(&stall_cnt_q))             stall_cnt_d = stall_cnt_q + 1'b1;
      if ((flush_d || flush_e) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int RA_W = 4;
  localparam int CNT_W = 4;
  localparam int TO = 15;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz ();
  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  always #5 clk = ~clk;

  // Model: length of the current run of memory-stalled cycles, sticky error, counters.
  int m_run, m_sc, m_fc;
  bit m_err;
  logic [1:0] exp_fa, exp_fb;
  logic exp_sf, exp_sd, exp_se, exp_sm, exp_fd, exp_fe, exp_fw, exp_req, exp_ms;

  task automatic model_reset();
    m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic calc_exp();
    bit ldr, acc;
    exp_fa = (hz.RegWriteM && hz.RA1E == hz.WA3M) ? 2'd2 :
             (hz.RegWriteW && hz.RA1E == hz.WA3W) ? 2'd1 : 2'd0;
    exp_fb = (hz.RegWriteM && hz.RA2E == hz.WA3M) ? 2'd2 :
             (hz.RegWriteW && hz.RA2E == hz.WA3W) ? 2'd1 : 2'd0;
    ldr = hz.MemtoRegE && (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
    acc = hz.MemWriteM || hz.MemtoRegM;
    exp_ms  = m_err || (!hz.mem_ready && (m_run > 0 || acc));
    exp_req = acc && !m_err;
    if (exp_ms) begin
      {exp_sf, exp_sd, exp_se, exp_sm, exp_fw} = 5'b11111;
      {exp_fd, exp_fe} = 2'b00;
    end else begin
      exp_sf = ldr || hz.PCWrPendingF;
      exp_sd = ldr;
      {exp_se, exp_sm, exp_fw} = 3'b000;
      exp_fd = hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenE;
      exp_fe = ldr || hz.BranchTakenE;
    end
  endtask

  task automatic step();
    calc_exp();
    if (!rst) begin
      if (hz.cnt_clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (exp_sf && m_sc < SAT) m_sc++;
        if ((exp_fd || exp_fe) && m_fc < SAT) m_fc++;
      end
      if (!m_err) begin
        if (exp_ms) begin
          m_run++;
          if (m_run > TO) m_err = 1;
        end else m_run = 0;
      end
    end
    @(posedge clk);
    #1;
    calc_exp();
  endtask

  task automatic clear_inputs();
    {hz.RA1D, hz.RA2D, hz.RA1E, hz.RA2E} = '0;
    hz.WA3E = 4'd9; hz.WA3M = 4'd10; hz.WA3W = 4'd11;
    {hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.MemWriteM, hz.MemtoRegM} = '0;
    {hz.PCWrPendingF, hz.BranchTakenE, hz.PCSrcW, hz.cnt_clr} = '0;
    hz.mem_ready = 1'b1;
    #1;
    calc_exp();
  endtask

  task automatic pulse_reset();
    rst = 1'b1; model_reset();
    #2;
    rst = 1'b0;
    #1;
    calc_exp();
  endtask

  task automatic test_reset();
    clear_inputs();
    @(posedge clk); #1;
    checks++;
    if ({hz.mem_timeout_err, hz.stall_cnt, hz.flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_regs: got err=%b sc=%0d fc=%0d want 0/0/0",
                         hz.mem_timeout_err, hz.stall_cnt, hz.flush_cnt);
    end
    hz.MemtoRegM = 1'b1; hz.mem_ready = 1'b0; #1;
    checks++;
    if ({hz.mem_req, hz.StallM} !== 2'b11) begin
      errors++; $display("FAIL reset_comb: got req=%b stallM=%b want 1/1", hz.mem_req, hz.StallM);
    end
    rst = 1'b0;
    clear_inputs();
    checks++;
    if ({hz.StallF, hz.StallM, hz.FlushD, hz.FlushW, hz.mem_req} !== 5'b0) begin
      errors++; $display("FAIL reset_idle: got %b want 00000",
                         {hz.StallF, hz.StallM, hz.FlushD, hz.FlushW, hz.mem_req});
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    hz.RegWriteM = 1; hz.WA3M = 3; hz.RegWriteW = 1; hz.WA3W = 3; hz.RA1E = 3; hz.RA2E = 7; #1;
    checks++;
    if (hz.ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_m_prio: got %b want 10", hz.ForwardAE);
    end
    hz.WA3M = 5; #1;
    checks++;
    if (hz.ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_w: got %b want 01", hz.ForwardAE);
    end
    hz.RA2E = 15; hz.WA3M = 15; hz.RegWriteW = 0; #1;
    checks++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b0010) begin
      errors++; $display("FAIL fwd_b_r15: got %b want 0010", {hz.ForwardAE, hz.ForwardBE});
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.MemtoRegE = 1; hz.WA3E = 2; hz.RA2D = 2; hz.RA1D = 6; #1;
    checks++;
    if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.StallE} !== 5'b11100) begin
      errors++; $display("FAIL load_use: got %b want 11100",
                         {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.StallE});
    end
    step();
    checks++;
    if (hz.stall_cnt !== CNT_W'(m_sc) || m_sc != 1) begin
      errors++; $display("FAIL load_use_cnt: got %0d want 1", hz.stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    hz.MemtoRegM = 1; hz.mem_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW} !== 5'b11111) begin
        errors++; $display("FAIL mem_wait_%0d: got %b want 11111", i,
                           {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW});
      end
      step();
    end
    hz.mem_ready = 1; #1;
    checks++;
    if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW} !== 5'b0) begin
      errors++; $display("FAIL mem_release: got %b want 00000",
                         {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW});
    end
    step();
    checks++;
    if (hz.StallM !== 1'b0) begin
      errors++; $display("FAIL mem_zero_wait: got stallM=%b want 0", hz.StallM);
    end
  endtask

  task automatic test_branch_in_stall();
    clear_inputs();
    hz.MemWriteM = 1; hz.mem_ready = 0; hz.BranchTakenE = 1; #1;
    checks++;
    if ({hz.FlushD, hz.FlushE, hz.StallE} !== 3'b001) begin
      errors++; $display("FAIL br_stall: got %b want 001", {hz.FlushD, hz.FlushE, hz.StallE});
    end
    step();
    step();
    hz.mem_ready = 1; #1;
    checks++;
    if ({hz.FlushD, hz.FlushE, hz.StallE} !== 3'b110) begin
      errors++; $display("FAIL br_release: got %b want 110", {hz.FlushD, hz.FlushE, hz.StallE});
    end
    step();
  endtask

  task automatic test_timeout();
    clear_inputs();
    hz.MemtoRegM = 1; hz.mem_ready = 0; #1;
    for (int i = 0; i <= TO; i++) begin
      checks++;
      if ({hz.StallM, hz.mem_timeout_err, hz.mem_req} !== 3'b101) begin
        errors++; $display("FAIL to_wait_%0d: got %b want 101", i,
                           {hz.StallM, hz.mem_timeout_err, hz.mem_req});
      end
      step();
    end
    hz.mem_ready = 1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({hz.StallF, hz.StallM, hz.mem_timeout_err, hz.mem_req} !== 4'b1110) begin
        errors++; $display("FAIL to_err_%0d: got %b want 1110", i,
                           {hz.StallF, hz.StallM, hz.mem_timeout_err, hz.mem_req});
      end
      step();
    end
    pulse_reset();
    checks++;
    if ({hz.StallM, hz.mem_timeout_err, hz.mem_req} !== 3'b001) begin
      errors++; $display("FAIL to_reset: got %b want 001",
                         {hz.StallM, hz.mem_timeout_err, hz.mem_req});
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    hz.MemtoRegM = 1; hz.mem_ready = 0; #1;
    step(); step();
    pulse_reset();
    hz.MemtoRegM = 0; #1;
    checks++;
    if ({hz.StallM, hz.mem_req} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_wait: got %b want 00", {hz.StallM, hz.mem_req});
    end
    hz.MemtoRegM = 1; hz.mem_ready = 1; #1;
    checks++;
    if ({hz.StallM, hz.mem_req} !== 2'b01) begin
      errors++; $display("FAIL rst_new_acc: got %b want 01", {hz.StallM, hz.mem_req});
    end
    step();
  endtask

  task automatic test_saturation();
    clear_inputs();
    hz.cnt_clr = 1; step(); hz.cnt_clr = 0;
    hz.PCWrPendingF = 1; #1;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (hz.stall_cnt !== CNT_W'(SAT) || hz.flush_cnt !== CNT_W'(SAT)) begin
      errors++; $display("FAIL sat_hold: got sc=%0d fc=%0d want %0d", hz.stall_cnt, hz.flush_cnt, SAT);
    end
    hz.cnt_clr = 1; step(); hz.cnt_clr = 0;
    checks++;
    if (hz.stall_cnt !== '0 || hz.flush_cnt !== '0) begin
      errors++; $display("FAIL sat_clr: got sc=%0d fc=%0d want 0", hz.stall_cnt, hz.flush_cnt);
    end
    step();
    checks++;
    if (hz.stall_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL clr_restart: got sc=%0d want 1", hz.stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [20:0] got, want;
    clear_inputs();
    for (int n = 0; n < 600; n++) begin
      hz.RA1D = 4'($urandom_range(0, 3)); hz.RA2D = 4'($urandom_range(0, 3));
      hz.RA1E = 4'($urandom_range(0, 3)); hz.RA2E = 4'($urandom_range(0, 3));
      hz.WA3E = 4'($urandom_range(0, 3)); hz.WA3M = 4'($urandom_range(0, 3));
      hz.WA3W = 4'($urandom_range(0, 3));
      hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
      hz.MemtoRegE = ($urandom_range(0, 3) == 0);
      hz.MemWriteM = ($urandom_range(0, 3) == 0); hz.MemtoRegM = ($urandom_range(0, 3) == 0);
      hz.PCWrPendingF = ($urandom_range(0, 7) == 0); hz.BranchTakenE = ($urandom_range(0, 7) == 0);
      hz.PCSrcW = ($urandom_range(0, 7) == 0);
      hz.mem_ready = (n >= 200 && n < 240) ? 1'b0 : ($urandom_range(0, 2) != 0);
      hz.cnt_clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1; model_reset();
      end else rst = 1'b0;
      #1;
      calc_exp();
      got  = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
              hz.FlushD, hz.FlushE, hz.FlushW, hz.mem_req, hz.mem_timeout_err,
              hz.stall_cnt, hz.flush_cnt};
      want = {exp_fa, exp_fb, exp_sf, exp_sd, exp_se, exp_sm, exp_fd, exp_fe, exp_fw,
              exp_req, m_err, CNT_W'(m_sc), CNT_W'(m_fc)};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL rand_cycle_%0d: got %b want %b", n, got, want);
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_branch_in_stall();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
